wgt_bram_arbiter: RTL and testbench

// - Shares the single read port (port B) of the weight/attention-vector BRAM between two schedulers.
//   - Requester 0 is the conv1 scheduler; requester 1 is the conv2 scheduler.
// - Each requester asks for a burst (base address + length). A whole burst is granted atomically.
// - The block drives the BRAM address, covers the BRAM read latency and returns tagged data beats.
// - Sits between the weight BRAM and the scheduler_conv* blocks. No grant is issued before the BRAM load completes.

---
 rtl/wgt_bram_arbiter.sv | 174 +++++++++++++++++
 tb/tb_wgt_bram_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wgt_bram_arbiter.sv
//==============================================================================
// Module   : wgt_bram_arbiter
// Brief    : Shares weight-BRAM read port B between the conv1/conv2 schedulers,
//            granting whole bursts and returning tagged, latency-aligned beats.
//            Build option: `WGT_ARB_FIXED_PRIO_EN selects strict priority
//            (requester 0 wins ties) instead of round-robin.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module wgt_bram_arbiter #(
    parameter int DATA_WIDTH    = 8,
    parameter int WEIGHT_ADDR_W = 15,
    parameter int LEN_W         = 16,
    parameter int BRAM_LATENCY  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    req_vld_i,
    output logic [1:0]                    req_rdy_o,
    input  logic [1:0][WEIGHT_ADDR_W-1:0] req_base_i,
    input  logic [1:0][LEN_W-1:0]         req_len_i,
    output logic [1:0]                    rsp_vld_o,
    output logic [DATA_WIDTH-1:0]         rsp_data_o,
    output logic                          rsp_last_o,
    output logic                          busy_o,
    output logic [WEIGHT_ADDR_W-1:0]      wgt_bram_addrb,
    output logic                          wgt_bram_enb,
    input  logic [DATA_WIDTH-1:0]         wgt_bram_dout,
    input  logic                          wgt_bram_load_done
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]               state;
    logic [1:0]               state_nxt;
    logic                     sel;
    logic                     accept;
    logic [LEN_W-1:0]         len_sel;
    logic [LEN_W-1:0]         len_q;
    logic [LEN_W-1:0]         cnt;
    logic [WEIGHT_ADDR_W-1:0] addr_q;
    logic                     owner;
    logic                     issue_last;
    logic [BRAM_LATENCY-1:0]  pipe_vld;
    logic [BRAM_LATENCY-1:0]  pipe_last;
    logic                     out_vld;
    logic                     out_last;

`ifdef WGT_ARB_FIXED_PRIO_EN
    always_comb begin
        sel = ~req_vld_i[0] & req_vld_i[1];
    end
`else
    logic ptr;

    // On contention the pointer names the requester that was not granted last.
    always_comb begin
        if (req_vld_i == 2'b11) begin
            sel = ptr;
        end else begin
            sel = req_vld_i[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (accept) begin
            ptr <= ~sel;
        end
    end
`endif

    assign len_sel    = req_len_i[sel];
    assign accept     = (state == S_IDLE) && !rst && wgt_bram_load_done && req_vld_i[sel];
    assign issue_last = (cnt == (len_q - LEN_W'(1)));
    assign out_vld    = pipe_vld[BRAM_LATENCY-1];
    assign out_last   = pipe_last[BRAM_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && (len_sel != '0)) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_last) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Leave as the final beat goes out; nothing else is in flight.
                if (out_vld && out_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_rdy_o = 2'b00;
        if (accept) begin
            req_rdy_o[sel] = 1'b1;
        end
        wgt_bram_enb = (state == S_ISSUE);
        busy_o       = (state != S_IDLE);
    end

    // addr_q is left on the final address so addrb holds outside ISSUE.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            len_q  <= '0;
            cnt    <= '0;
            owner  <= 1'b0;
        end else if (accept) begin
            owner <= sel;
            len_q <= len_sel;
            cnt   <= '0;
            if (len_sel != '0) begin
                addr_q <= req_base_i[sel];
            end
        end else if (state == S_ISSUE) begin
            cnt <= cnt + LEN_W'(1);
            if (!issue_last) begin
                addr_q <= addr_q + WEIGHT_ADDR_W'(1);
            end
        end
    end

    assign wgt_bram_addrb = addr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld  <= '0;
            pipe_last <= '0;
        end else begin
            pipe_vld[0]  <= wgt_bram_enb;
            pipe_last[0] <= wgt_bram_enb & issue_last;
            for (int i = BRAM_LATENCY - 1; i > 0; i--) begin
                pipe_vld[i]  <= pipe_vld[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    always_comb begin
        rsp_vld_o  = 2'b00;
        rsp_data_o = '0;
        rsp_last_o = 1'b0;
        if (out_vld) begin
            rsp_vld_o[owner] = 1'b1;
            rsp_data_o       = wgt_bram_dout;
            rsp_last_o       = out_last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wgt_bram_arbiter.sv
//==============================================================================
// Module   : tb_wgt_bram_arbiter
// Brief    : Directed self-checking bench for wgt_bram_arbiter with a
//            two-cycle BRAM model.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_wgt_bram_arbiter;

    localparam int LAT = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [1:0]        req_vld;
    logic [1:0]        req_rdy;
    logic [1:0][14:0]  req_base;
    logic [1:0][15:0]  req_len;
    logic [1:0]        rsp_vld;
    logic [7:0]        rsp_data;
    logic              rsp_last;
    logic              busy;
    logic [14:0]       addrb;
    logic              enb;
    logic [7:0]        dout;
    logic              load_done;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    wgt_bram_arbiter #(
        .DATA_WIDTH   (8),
        .WEIGHT_ADDR_W(15),
        .LEN_W        (16),
        .BRAM_LATENCY (LAT)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .req_vld_i         (req_vld),
        .req_rdy_o         (req_rdy),
        .req_base_i        (req_base),
        .req_len_i         (req_len),
        .rsp_vld_o         (rsp_vld),
        .rsp_data_o        (rsp_data),
        .rsp_last_o        (rsp_last),
        .busy_o            (busy),
        .wgt_bram_addrb    (addrb),
        .wgt_bram_enb      (enb),
        .wgt_bram_dout     (dout),
        .wgt_bram_load_done(load_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] mem_val(input int a);
        int v;
        v = (a & 32'h7FFF) * 37 + ((a & 32'h7FFF) >>> 7) + 90;
        return v[7:0];
    endfunction

    // Two-register BRAM model: address in cycle t, data in cycle t+2.
    logic [7:0] mem [0:32767];
    logic [7:0] d1, d2;
    always @(posedge clk) begin
        if (enb) d1 <= mem[addrb];
        d2 <= d1;
    end
    assign dout = d2;

    typedef struct {
        int         cyc;
        logic [1:0] vld;
        logic [7:0] data;
        logic       last;
    } beat_t;

    beat_t beats[$];
    int    acyc[$];
    int    aval[$];
    int    bad_both = 0;
    int    bad_idle = 0;

    always @(negedge clk) begin
        beat_t b;
        if (enb) begin
            acyc.push_back(cyc);
            aval.push_back(int'(addrb));
        end
        if (rsp_vld != 2'b00) begin
            b.cyc = cyc; b.vld = rsp_vld; b.data = rsp_data; b.last = rsp_last;
            beats.push_back(b);
        end
        if (rsp_vld == 2'b11) bad_both++;
        if (rsp_vld == 2'b00 && (rsp_data != 8'h00 || rsp_last)) bad_idle++;
    end

    // Tasks start and end at the drive point: 1 ns after a rising edge.
    task automatic request(input int r, input int base, input int len, output int t_acc);
        int k;
        bit got;
        k = 0; got = 0; t_acc = -1;
        req_vld[r] = 1'b1; req_base[r] = 15'(base); req_len[r] = 16'(len);
        while (!got && k < 100) begin
            @(negedge clk);
            if (req_rdy[r]) begin got = 1; t_acc = cyc; end
            @(posedge clk); #1; k++;
        end
        req_vld[r] = 1'b0; req_base[r] = 15'h2ABC; req_len[r] = 16'hFFFF;
        n_chk++;
        if (!got) begin n_fail++; $display("FAIL grant_timeout req%0d got none required grant", r); end
    endtask

    task automatic wait_idle(input string name, output int t_idle);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 300) begin @(negedge clk); k++; end
        t_idle = cyc;
        n_chk++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL %s idle_timeout busy=%b required 0", name, busy); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_done = 1'b1; req_vld = 2'b11;
        req_base[0] = 15'd0;  req_len[0] = 16'd2;
        req_base[1] = 15'd50; req_len[1] = 16'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_chk++; if (req_rdy !== 2'b00)  begin n_fail++; $display("FAIL reset rdy got %b required 00", req_rdy); end
        n_chk++; if (rsp_vld !== 2'b00)  begin n_fail++; $display("FAIL reset rsp_vld got %b required 00", rsp_vld); end
        n_chk++; if (rsp_data !== 8'h00) begin n_fail++; $display("FAIL reset rsp_data got %h required 00", rsp_data); end
        n_chk++; if (rsp_last !== 1'b0)  begin n_fail++; $display("FAIL reset rsp_last got %b required 0", rsp_last); end
        n_chk++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset busy got %b required 0", busy); end
        n_chk++; if (enb !== 1'b0)       begin n_fail++; $display("FAIL reset enb got %b required 0", enb); end
        n_chk++; if (addrb !== 15'd0)    begin n_fail++; $display("FAIL reset addrb got %0d required 0", addrb); end
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        int g_own[3], g_cyc[3], e_own[3], e_base[3], e_len[3];
        int ng, k, n0, idx, t_idle, total;
        ng = 0; k = 0; n0 = beats.size(); total = 0;
        for (int j = 0; j < 3; j++) begin g_own[j] = -1; g_cyc[j] = -1; end
`ifdef WGT_ARB_FIXED_PRIO_EN
        e_own = '{0, 0, 0}; e_base = '{0, 0, 0}; e_len = '{2, 2, 2};
`else
        e_own = '{0, 1, 0}; e_base = '{0, 50, 0}; e_len = '{2, 3, 2};
`endif
        rst = 1'b0;
        while (ng < 3 && k < 100) begin
            @(negedge clk);
            if (req_rdy != 2'b00) begin g_own[ng] = req_rdy[1] ? 1 : 0; g_cyc[ng] = cyc; ng++; end
            @(posedge clk); #1; k++;
        end
        req_vld = 2'b00;
        wait_idle("contention", t_idle);
        for (int j = 0; j < 3; j++) begin
            n_chk++;
            if (g_own[j] !== e_own[j]) begin n_fail++; $display("FAIL contention grant%0d owner got %0d required %0d", j, g_own[j], e_own[j]); end
            total += e_len[j];
        end
        for (int j = 1; j < 3; j++) begin
            n_chk++;
            if (g_cyc[j] - g_cyc[j-1] !== e_len[j-1] + LAT + 1)
                begin n_fail++; $display("FAIL contention grant%0d spacing got %0d required %0d", j, g_cyc[j] - g_cyc[j-1], e_len[j-1] + LAT + 1); end
        end
        n_chk++;
        if (beats.size() - n0 !== total) begin n_fail++; $display("FAIL contention beat_count got %0d required %0d", beats.size() - n0, total); end
        idx = n0;
        for (int j = 0; j < 3; j++) begin
            for (int i = 0; i < e_len[j]; i++) begin
                if (idx < beats.size()) begin
                    n_chk++;
                    if (beats[idx].vld !== 2'(1 << e_own[j]) || beats[idx].data !== mem_val(e_base[j] + i) || beats[idx].last !== (i == e_len[j] - 1))
                        begin n_fail++; $display("FAIL contention beat%0d got vld=%b data=%h last=%b required vld=%b data=%h last=%b", idx - n0,
                            beats[idx].vld, beats[idx].data, beats[idx].last, 2'(1 << e_own[j]), mem_val(e_base[j] + i), (i == e_len[j] - 1)); end
                end
                idx++;
            end
        end
    endtask

    task automatic test_single_burst();
        int t, t_idle, n0, a0;
        n0 = beats.size(); a0 = acyc.size();
        request(0, 100, 4, t);
        wait_idle("single", t_idle);
        n_chk++; if (acyc.size() - a0 !== 4) begin n_fail++; $display("FAIL single addr_count got %0d required 4", acyc.size() - a0); end
        n_chk++; if (beats.size() - n0 !== 4) begin n_fail++; $display("FAIL single beat_count got %0d required 4", beats.size() - n0); end
        for (int i = 0; i < 4 && a0 + i < acyc.size(); i++) begin
            n_chk++;
            if (acyc[a0+i] !== t + 1 + i || aval[a0+i] !== 100 + i)
                begin n_fail++; $display("FAIL single addr%0d got cyc=%0d addr=%0d required cyc=%0d addr=%0d", i, acyc[a0+i] - t, aval[a0+i], 1 + i, 100 + i); end
        end
        for (int i = 0; i < 4 && n0 + i < beats.size(); i++) begin
            n_chk++;
            if (beats[n0+i].cyc !== t + LAT + 1 + i || beats[n0+i].vld !== 2'b01 || beats[n0+i].data !== mem_val(100 + i) || beats[n0+i].last !== (i == 3))
                begin n_fail++; $display("FAIL single beat%0d got T+%0d vld=%b data=%h last=%b required T+%0d vld=01 data=%h last=%b", i,
                    beats[n0+i].cyc - t, beats[n0+i].vld, beats[n0+i].data, beats[n0+i].last, LAT + 1 + i, mem_val(100 + i), (i == 3)); end
        end
        n_chk++; if (t_idle !== t + 7) begin n_fail++; $display("FAIL single idle_cycle got T+%0d required T+7", t_idle - t); end
        @(negedge clk);
        n_chk++; if (addrb !== 15'd103 || enb !== 1'b0) begin n_fail++; $display("FAIL single addr_hold got addr=%0d enb=%b required 103 0", addrb, enb); end
        @(posedge clk); #1;
    endtask

    task automatic test_gating();
        int t_idle, n0;
        bit bad;
        n0 = beats.size(); bad = 0;
        load_done = 1'b0;
        req_vld[1] = 1'b1; req_base[1] = 15'd200; req_len[1] = 16'd2;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_chk++;
            if (req_rdy !== 2'b00) begin n_fail++; $display("FAIL gating rdy_blocked cycle%0d got %b required 00", i, req_rdy); end
            @(posedge clk); #1;
        end
        load_done = 1'b1;
        @(negedge clk);
        n_chk++; if (req_rdy !== 2'b10) begin n_fail++; $display("FAIL gating first_grant got %b required 10", req_rdy); end
        @(posedge clk); #1;
        req_vld = 2'b00;
        wait_idle("gating", t_idle);
        n_chk++; if (beats.size() - n0 !== 2) begin n_fail++; $display("FAIL gating beat_count got %0d required 2", beats.size() - n0); end
        for (int i = 0; i < 2 && n0 + i < beats.size(); i++) begin
            n_chk++;
            if (beats[n0+i].vld !== 2'b10 || beats[n0+i].data !== mem_val(200 + i))
                begin n_fail++; $display("FAIL gating beat%0d got vld=%b data=%h required vld=10 data=%h", i, beats[n0+i].vld, beats[n0+i].data, mem_val(200 + i)); end
        end
    endtask

    task automatic test_len_zero();
        int t, n0, a0;
        n0 = beats.size(); a0 = acyc.size();
        request(0, 5, 0, t);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            n_chk++;
            if (busy !== 1'b0 || enb !== 1'b0 || rsp_vld !== 2'b00 || addrb !== 15'd201)
                begin n_fail++; $display("FAIL len_zero cycle%0d got busy=%b enb=%b vld=%b addr=%0d required 0 0 00 201", i, busy, enb, rsp_vld, addrb); end
            @(posedge clk); #1;
        end
        n_chk++;
        if (beats.size() !== n0 || acyc.size() !== a0)
            begin n_fail++; $display("FAIL len_zero activity got beats=%0d addrs=%0d required 0 0", beats.size() - n0, acyc.size() - a0); end
    endtask

    task automatic test_wrap();
        int t, t_idle, n0, a0, ea;
        n0 = beats.size(); a0 = acyc.size();
        request(0, 32766, 4, t);
        wait_idle("wrap", t_idle);
        n_chk++; if (acyc.size() - a0 !== 4) begin n_fail++; $display("FAIL wrap addr_count got %0d required 4", acyc.size() - a0); end
        for (int i = 0; i < 4 && a0 + i < acyc.size(); i++) begin
            ea = (32766 + i) % 32768;
            n_chk++;
            if (aval[a0+i] !== ea) begin n_fail++; $display("FAIL wrap addr%0d got %0d required %0d", i, aval[a0+i], ea); end
            if (n0 + i < beats.size()) begin
                n_chk++;
                if (beats[n0+i].data !== mem_val(ea)) begin n_fail++; $display("FAIL wrap data%0d got %h required %h", i, beats[n0+i].data, mem_val(ea)); end
            end
        end
    endtask

    task automatic test_reset_midburst();
        int t, t_idle, nb, n0;
        request(1, 300, 10, t);
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        nb = beats.size();
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0 || enb !== 1'b0 || addrb !== 15'd0 || rsp_vld !== 2'b00 || rsp_data !== 8'h00 || rsp_last !== 1'b0 || req_rdy !== 2'b00)
            begin n_fail++; $display("FAIL midreset outputs got busy=%b enb=%b addr=%0d vld=%b data=%h last=%b rdy=%b required all 0",
                busy, enb, addrb, rsp_vld, rsp_data, rsp_last, req_rdy); end
        repeat (12) @(posedge clk);
        #1;
        n_chk++; if (beats.size() !== nb) begin n_fail++; $display("FAIL midreset stray_beats got %0d required 0", beats.size() - nb); end
        n0 = beats.size();
        request(0, 400, 3, t);
        wait_idle("midreset", t_idle);
        n_chk++; if (beats.size() - n0 !== 3) begin n_fail++; $display("FAIL midreset fresh_count got %0d required 3", beats.size() - n0); end
        for (int i = 0; i < 3 && n0 + i < beats.size(); i++) begin
            n_chk++;
            if (beats[n0+i].vld !== 2'b01 || beats[n0+i].data !== mem_val(400 + i) || beats[n0+i].last !== (i == 2))
                begin n_fail++; $display("FAIL midreset fresh%0d got vld=%b data=%h last=%b required 01 %h %b", i,
                    beats[n0+i].vld, beats[n0+i].data, beats[n0+i].last, mem_val(400 + i), (i == 2)); end
        end
    endtask

    task automatic test_invariants();
        n_chk++; if (bad_both !== 0) begin n_fail++; $display("FAIL onehot both_vld_cycles got %0d required 0", bad_both); end
        n_chk++; if (bad_idle !== 0) begin n_fail++; $display("FAIL idle_outputs nonzero_cycles got %0d required 0", bad_idle); end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = mem_val(i);
        test_reset();
        test_contention();
        test_single_burst();
        test_gating();
        test_len_zero();
        test_wrap();
        test_reset_midburst();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d required completion", cyc);
        $fatal(1);
    end

endmodule

`default_nettype wire
